// File: rtl/usb_bulk_in_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_bulk_in_fifo_if
// Brief    : Byte-wide AXI-Stream link used on both sides of the bulk-IN FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_bulk_in_fifo_if;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic [7:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface
`default_nettype wire

// File: rtl/usb_bulk_in_fifo.sv
`default_nettype none
// ============================================================================
// Module   : usb_bulk_in_fifo
// Brief    : Packet-aware bulk-IN buffer; releases whole committed packets and
//            optionally holds each sent packet for ACK/replay
//            (macro USB_BULK_IN_REPLAY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module usb_bulk_in_fifo #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_PACKET = 512
) (
    input  wire                 clock,
    input  wire                 reset,
    usb_bulk_in_fifo_if.slave   s_axis,
    usb_bulk_in_fifo_if.master  m_axis,
    output logic                has_data_o,
    input  wire                 ack_i,
    input  wire                 rollback_i,
    output logic [ADDR_WIDTH:0] level_o
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;
    localparam int c_LEN_W = $clog2(MAX_PACKET);

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t               c_FULL     = ptr_t'(c_DEPTH);
    localparam logic [c_LEN_W-1:0] c_LEN_LAST = c_LEN_W'(MAX_PACKET - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    logic [8:0]         mem [c_DEPTH];

    state_t             r_state;
    ptr_t               r_wr_ptr;
    ptr_t               r_wr_commit;
    ptr_t               r_rd_ptr;
    ptr_t               r_rd_commit;
    ptr_t               r_pkt_count;
    logic [c_LEN_W-1:0] r_wr_len;
    logic               r_m_tvalid;
    logic [8:0]         r_rd_data;

    state_t             w_state_nxt;
    ptr_t               w_rd_ptr_nxt;
    ptr_t               w_rd_commit_nxt;
    ptr_t               w_wr_ptr_nxt;
    ptr_t               w_pkt_count_nxt;
    logic               w_m_tvalid_nxt;
    logic               w_rd_en;
    logic               w_pkt_dec;
    logic               w_full;
    logic               w_wr_fire;
    logic               w_wr_last;
    logic               w_m_fire;

    // Space is measured against rd_commit so unacknowledged bytes stay intact
    assign w_full          = (r_wr_ptr - r_rd_commit) == c_FULL;
    assign s_axis.tready   = !w_full;
    assign w_wr_fire       = s_axis.tvalid && !w_full;
    assign w_wr_last       = s_axis.tlast || (r_wr_len == c_LEN_LAST);
    assign w_wr_ptr_nxt    = r_wr_ptr + ptr_t'(w_wr_fire);
    assign w_m_fire        = r_m_tvalid && m_axis.tready;
    assign w_pkt_count_nxt = r_pkt_count + ptr_t'(w_wr_fire && w_wr_last) - ptr_t'(w_pkt_dec);

    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tdata  = r_rd_data[7:0];
    assign m_axis.tlast  = r_rd_data[8];

    always_comb begin
        w_state_nxt     = r_state;
        w_rd_en         = 1'b0;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_rd_commit_nxt = r_rd_commit;
        w_m_tvalid_nxt  = r_m_tvalid;
        w_pkt_dec       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rd_ptr != r_wr_commit) begin
                    w_rd_en      = 1'b1;
                    w_rd_ptr_nxt = r_rd_ptr + ptr_t'(1);
                    w_state_nxt  = S_FETCH;
                end
            end
            S_FETCH: begin
                w_m_tvalid_nxt = 1'b1;
                w_state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (w_m_fire) begin
                    if (r_rd_data[8]) begin
                        w_m_tvalid_nxt = 1'b0;
`ifdef USB_BULK_IN_REPLAY_EN
                        w_state_nxt    = S_WAIT;
`else
                        w_rd_commit_nxt = r_rd_ptr;
                        w_pkt_dec       = 1'b1;
                        w_state_nxt     = S_IDLE;
`endif
                    end else begin
                        // Read issued now keeps tvalid high with no bubble
                        w_rd_en      = 1'b1;
                        w_rd_ptr_nxt = r_rd_ptr + ptr_t'(1);
                    end
                end
            end
            S_WAIT: begin
`ifdef USB_BULK_IN_REPLAY_EN
                if (ack_i) begin
                    w_rd_commit_nxt = r_rd_ptr;
                    w_pkt_dec       = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else if (rollback_i) begin
                    w_rd_ptr_nxt = r_rd_commit;
                    w_state_nxt  = S_IDLE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
`ifdef USB_BULK_IN_REPLAY_EN
        // Rollback during delivery aborts the packet; it is replayed from rd_commit
        if (rollback_i && (r_state == S_FETCH || r_state == S_SEND)) begin
            w_m_tvalid_nxt = 1'b0;
            w_rd_en        = 1'b0;
            w_rd_ptr_nxt   = r_rd_commit;
            w_state_nxt    = S_IDLE;
        end
`endif
    end

`ifndef USB_BULK_IN_REPLAY_EN
    logic unused_ctl;
    assign unused_ctl = ack_i ^ rollback_i;
`endif

    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {w_wr_last, s_axis.tdata};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_rd_commit <= '0;
            r_pkt_count <= '0;
            r_wr_len    <= '0;
            r_m_tvalid  <= 1'b0;
            r_rd_data   <= '0;
            has_data_o  <= 1'b0;
            level_o     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_rd_commit <= w_rd_commit_nxt;
            r_pkt_count <= w_pkt_count_nxt;
            r_m_tvalid  <= w_m_tvalid_nxt;
            has_data_o  <= w_pkt_count_nxt != '0;
            level_o     <= w_wr_ptr_nxt - w_rd_commit_nxt;
            if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_wr_len    <= '0;
                    r_wr_commit <= r_wr_ptr + ptr_t'(1);
                end else begin
                    r_wr_len <= r_wr_len + c_LEN_W'(1);
                end
            end
            if (w_rd_en) begin
                r_rd_data <= mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

endmodule
`default_nettype wire
